// File: rtl/logic_pipe.sv
// logic_pipe: handshaked pipeline computing z = ((a0 | ~a1) & (a2 | a3)) ^ a0
// bitwise over W-bit operands, DEPTH stages deep, with a wrapping count of
// completed output transfers.
module logic_pipe #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a0,
    input  logic [W-1:0]     a1,
    input  logic [W-1:0]     a2,
    input  logic [W-1:0]     a3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     z,
    output logic [CNT_W-1:0] xfer_cnt
);

    // Elaboration-time guard on the supported parameter ranges.
    if (W < 1 || W > 64) begin : g_bad_w
        $error("logic_pipe: W must be in 1..64");
    end
    if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
        $error("logic_pipe: DEPTH must be in 2..8");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("logic_pipe: CNT_W must be at least 1");
    end

    // Stage valid bits, indexed 1..DEPTH so stage k lives at bit k.
    logic [DEPTH:1]   v_q;
    logic [DEPTH:1]   v_d;
    // Per-stage "may load this cycle" chain.
    logic [DEPTH:1]   rdy_c;

    // Stage 1 keeps the partial term and the matching a0 of the same beat.
    logic [W-1:0]     tmp_q;
    logic [W-1:0]     tmp_d;
    logic [W-1:0]     a0c_q;
    logic [W-1:0]     a0c_d;

    // Stages 2..DEPTH carry the finished result.
    logic [W-1:0]     res_q [DEPTH:2];
    logic [W-1:0]     res_d [DEPTH:2];

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             in_xfer_c;
    logic             out_xfer_c;

    // Ready chain: a stage may load if it is empty or everything below it moves.
    always_comb begin : ready_chain
        rdy_c        = '0;
        rdy_c[DEPTH] = out_ready | ~v_q[DEPTH];
        for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
            rdy_c[k] = rdy_c[k+1] | ~v_q[k];
        end
    end

    assign in_ready   = rdy_c[1] & ~rst;
    assign in_xfer_c  = in_valid & in_ready;
    assign out_xfer_c = v_q[DEPTH] & out_ready;

    // Next-state: each stage either loads from upstream or holds.
    always_comb begin : next_state
        v_d   = v_q;
        tmp_d = tmp_q;
        a0c_d = a0c_q;
        res_d = res_q;
        cnt_d = cnt_q;

        if (rdy_c[1]) begin
            v_d[1] = in_xfer_c;
            if (in_xfer_c) begin
                tmp_d = (a0 | ~a1) & (a2 | a3);
                a0c_d = a0;
            end
        end

        if (rdy_c[2]) begin
            v_d[2] = v_q[1];
            if (v_q[1]) begin
                res_d[2] = tmp_q ^ a0c_q;
            end
        end

        for (int k = 3; k <= int'(DEPTH); k++) begin
            if (rdy_c[k]) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) begin
                    res_d[k] = res_q[k-1];
                end
            end
        end

        if (out_xfer_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous clear of valids, data and counter.
    always_ff @(posedge clk) begin : state_regs
        if (rst) begin
            v_q   <= '0;
            tmp_q <= '0;
            a0c_q <= '0;
            for (int k = 2; k <= int'(DEPTH); k++) begin
                res_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            tmp_q <= tmp_d;
            a0c_q <= a0c_d;
            for (int k = 2; k <= int'(DEPTH); k++) begin
                res_q[k] <= res_d[k];
            end
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = v_q[DEPTH];
    assign z         = res_q[DEPTH];
    assign xfer_cnt  = cnt_q;

    // A stalled output must not change until it is taken.
    a_stall_hold : assert property (
        @(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(z))
    );

endmodule

// File: tb/tb_logic_pipe.sv
// Scoreboard bench for logic_pipe (W=8, DEPTH=3, CNT_W=4): the driver pushes
// hand-computed results on each accepted beat, the monitor pops on each output
// transfer, and the driver checks control signals and the counter directly.
module tb_logic_pipe;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a0;
    logic [W-1:0]     a1;
    logic [W-1:0]     a2;
    logic [W-1:0]     a3;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     z;
    logic [CNT_W-1:0] xfer_cnt;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic last_acc;

    // Directed vectors with hand-computed results.
    logic [W-1:0] t_a0 [8] = '{8'h0A, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hF0, 8'h0F, 8'h3C};
    logic [W-1:0] t_a1 [8] = '{8'h06, 8'h00, 8'h5A, 8'h00, 8'hFF, 8'hCC, 8'h33, 8'hA5};
    logic [W-1:0] t_a2 [8] = '{8'h03, 8'hFF, 8'h00, 8'h0F, 8'hFF, 8'hAA, 8'h0C, 8'h96};
    logic [W-1:0] t_a3 [8] = '{8'h04, 8'h00, 8'h00, 8'hF0, 8'hFF, 8'h00, 8'h30, 8'h41};
    logic [W-1:0] t_z  [8] = '{8'h09, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h52, 8'h03, 8'h6A};

    logic_pipe #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a0        (a0),
        .a1        (a1),
        .a2        (a2),
        .a3        (a3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endfunction

    // Monitor: every output transfer must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: actual z %0h required no output", z);
            end else begin
                chk("z_order", 32'(z), 32'(exp_q.pop_front()));
            end
        end
    end

    // One cycle: drive after the edge, decide acceptance after the monitor ran.
    task automatic step(input logic v, input int vec, input logic ordy);
        @(posedge clk);
        #1;
        in_valid  = v;
        a0        = t_a0[vec];
        a1        = t_a1[vec];
        a2        = t_a2[vec];
        a3        = t_a3[vec];
        out_ready = ordy;
        @(negedge clk);
        #1;
        last_acc = in_valid && in_ready;
        if (last_acc) exp_q.push_back(t_z[vec]);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            step(1'b0, 0, 1'b1);
            guard++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'(0));
        step(1'b0, 0, 1'b1);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            #1;
            chk("in_ready_during_reset", 32'(in_ready), 32'(0));
            exp_q.delete();
            @(posedge clk);
            #1;
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_z", 32'(z), 32'(0));
        chk("rst_xfer_cnt", 32'(xfer_cnt), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
    endtask

    initial begin
        int sent;
        int guard;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0;
        last_acc = 1'b0;

        do_reset(2);

        // Single beat and latency.
        step(1'b1, 0, 1'b1);
        chk("single_accept", 32'(last_acc), 32'(1));
        step(1'b0, 0, 1'b1);
        chk("lat_edge0_valid", 32'(out_valid), 32'(0));
        step(1'b0, 0, 1'b1);
        chk("lat_edge1_valid", 32'(out_valid), 32'(0));
        step(1'b0, 0, 1'b1);
        chk("lat_edge2_valid", 32'(out_valid), 32'(1));
        chk("lat_edge2_z", 32'(z), 32'(8'h09));
        step(1'b0, 0, 1'b1);
        chk("single_xfer_cnt", 32'(xfer_cnt), 32'(1));
        chk("single_drained", 32'(out_valid), 32'(0));

        // Streaming at full throughput.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i, 1'b1);
            chk("stream_in_ready", 32'(last_acc), 32'(1));
        end
        drain();
        chk("stream_xfer_cnt", 32'(xfer_cnt), 32'(9));

        // Backpressure: only DEPTH beats fit, output held stable.
        sent = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1 + sent, 1'b0);
            if (last_acc) sent++;
        end
        chk("bp_accepted", 32'(sent), 32'(3));
        chk("bp_in_ready", 32'(in_ready), 32'(0));
        chk("bp_out_valid", 32'(out_valid), 32'(1));
        chk("bp_z_held", 32'(z), 32'(8'hFF));
        step(1'b1, 1 + sent, 1'b0);
        chk("bp_still_full", 32'(last_acc), 32'(0));
        chk("bp_z_held2", 32'(z), 32'(8'hFF));
        guard = 0;
        while (sent < 5 && guard < 20) begin
            step(1'b1, 1 + sent, 1'b1);
            if (last_acc) sent++;
            guard++;
        end
        chk("bp_all_sent", 32'(sent), 32'(5));
        drain();
        chk("bp_xfer_cnt", 32'(xfer_cnt), 32'(14));

        // Bubble collapse while the output is stalled.
        step(1'b1, 6, 1'b0);
        repeat (3) step(1'b0, 0, 1'b0);
        chk("bub_first_valid", 32'(out_valid), 32'(1));
        chk("bub_first_z", 32'(z), 32'(8'h03));
        step(1'b1, 7, 1'b0);
        chk("bub_second_accept", 32'(last_acc), 32'(1));
        repeat (2) begin
            step(1'b0, 0, 1'b0);
            chk("bub_in_ready", 32'(in_ready), 32'(1));
            chk("bub_z_stable", 32'(z), 32'(8'h03));
        end

        // Counter wrap at CNT_W=4: transfers 15, 16, 17.
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        chk("wrap_cnt15", 32'(xfer_cnt), 32'(15));
        chk("wrap_second_z", 32'(z), 32'(8'h6A));
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        chk("wrap_cnt16", 32'(xfer_cnt), 32'(0));
        chk("wrap_empty", 32'(out_valid), 32'(0));
        step(1'b1, 0, 1'b1);
        drain();
        chk("wrap_cnt17", 32'(xfer_cnt), 32'(1));

        // Reset mid-stream discards in-flight beats.
        step(1'b1, 1, 1'b0);
        step(1'b1, 2, 1'b0);
        step(1'b1, 3, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("mid_full_valid", 32'(out_valid), 32'(1));
        do_reset(1);
        repeat (5) begin
            step(1'b0, 0, 1'b1);
            chk("mid_no_stale", 32'(out_valid), 32'(0));
        end
        step(1'b1, 5, 1'b1);
        drain();
        chk("mid_after_cnt", 32'(xfer_cnt), 32'(1));
        chk("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/logic_pipe.md
# logic_pipe

Parametrised, handshaked pipeline evaluating the per-bit function z = ((a0 | ~a1) & (a2 | a3)) ^ a0 on W-bit operand vectors. Successor to the single-bit assignment-style examples in the simulation directory. Adds configurable width and depth, a valid/ready flow-control interface with full-throughput backpressure, synchronous reset, and a transfer counter. Sits between a stimulus source and a checker/consumer in simulation tops, and is synthesisable.

## Interface
- W, default 8: operand and result width, 1..64.
- DEPTH, default 2: pipeline stages, 2..8.
- CNT_W, default 16: width of the transfer counter.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set on a0..a3 is valid.
- in_ready  out  1  pipeline accepts an operand set this cycle.
- a0, a1, a2, a3  in  W each  operand vectors.
- out_valid  out  1  z holds a valid result.
- out_ready  in  1  consumer accepts z this cycle.
- z  out  W  result.
- xfer_cnt  out  CNT_W  count of completed output transfers, wrapping.

## Operation
- Each stage k (1..DEPTH) holds a valid bit v[k] and data registers.
- Stage 1 captures tmp = (a0 | ~a1) & (a2 | a3) and a copy of a0 from the same input beat. They are aligned, never mixed across beats.
- Stage 2 captures tmp ^ a0 from stage 1.
- Stages 3..DEPTH delay the result unchanged.
- z and out_valid come from stage DEPTH.
- Ready chain, combinational:
  - rdy[DEPTH] = out_ready | ~v[DEPTH]
  - rdy[k] = rdy[k+1] | ~v[k]
  - in_ready = rdy[1] & ~rst
- Stage k loads from stage k-1, or from the input when k = 1, when rdy[k] is 1.
  - On a load, v[k] takes the upstream valid, which is in_valid & in_ready for stage 1.
  - When rdy[k] is 0, stage k holds its data and valid bit.
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- xfer_cnt increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- Bubbles collapse: an empty stage always accepts, even when the stages downstream of it are stalled.
- No combinational path from a0..a3 or in_valid to z or out_valid.
- Paths from out_ready to in_ready are combinational by design.

## Timing
- Reset: while rst = 1 at a rising edge:
  - all v[k] = 0, all data registers = 0, xfer_cnt = 0.
  - in_ready = 0 during the reset cycle; inputs are ignored.
- After reset: out_valid = 0, z = 0, xfer_cnt = 0, and in_ready = 1 in the first cycle with rst = 0.
- Latency: a beat accepted at edge n appears on z with out_valid = 1 after edge n+DEPTH-1, provided there is no stall.
- Throughput: one beat per cycle while out_ready = 1.
- Stall: while out_valid = 1 and out_ready = 0, z and out_valid are held stable. The pipeline absorbs up to DEPTH beats, then in_ready = 0.
- Full pipeline with out_ready = 1 and in_valid = 1: input accept and output transfer occur in the same cycle, so occupancy is unchanged.
- Reset mid-operation: all in-flight beats are discarded with no output transfer, and xfer_cnt returns to 0.
- xfer_cnt updates at the edge of the transfer and is visible the following cycle.

## Test plan
- Single beat, W=4, DEPTH=2: a0=4'b1010, a1=4'b0110, a2=4'b0011, a3=4'b0100, out_ready=1 -> z=4'b1001 with out_valid=1 one cycle after acceptance; xfer_cnt becomes 1.
- Streaming, W=8, DEPTH=4: 100 random beats, out_ready=1 constantly -> in_ready never drops; outputs are in order and match the reference model; 3-cycle latency; xfer_cnt=100.
- Backpressure, DEPTH=3: out_ready=0 while feeding 5 beats -> exactly 3 accepted, then in_ready=0 and z held stable. Release out_ready -> the 5 results arrive in order with no loss or duplication.
- Bubble collapse, DEPTH=4: one beat, 3 idle cycles, one beat, with out_ready=0 throughout -> both beats are resident, out_valid=1 on the first, and in_ready stays 1.
- Reset mid-stream: rst=1 for one cycle with 3 beats in flight -> out_valid=0, z=0, xfer_cnt=0 next cycle; in_ready=1 the cycle after rst falls; the stale beats never appear.
- Counter wrap, CNT_W=4: 17 output transfers -> xfer_cnt reads 15 after 15 transfers, 0 after 16, and 1 after 17.
